// File: rtl/frv_pipeline_fifo_if.sv
// Handshake bundle between pipeline stage N, the elastic queue and stage N+1.
// The queue side uses the slave modport; the stage side uses master.
interface frv_pipeline_fifo_if #(
  parameter int unsigned RLEN  = 8,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [RLEN-1:0] i_data;
  logic            i_valid;
  logic            o_busy;
  logic [RLEN-1:0] mr_data;
  logic            flush;
  logic [RLEN-1:0] flush_dat;
  logic [RLEN-1:0] o_data;
  logic            o_valid;
  logic            i_busy;
  logic [CW-1:0]   o_count;

  modport slave (
    input  i_data, i_valid, flush, flush_dat, i_busy,
    output o_busy, mr_data, o_data, o_valid, o_count
  );

  modport master (
    output i_data, i_valid, flush, flush_dat, i_busy,
    input  o_busy, mr_data, o_data, o_valid, o_count
  );
endinterface

// File: rtl/frv_pipeline_fifo.sv
// Elastic DEPTH-entry pipeline queue with registered head, occupancy and flush-with-data.
// o_busy/o_valid/o_count decode registered count only, so no i_busy -> o_busy path exists.
module frv_pipeline_fifo #(
  parameter int unsigned RLEN  = 8,
  parameter int unsigned DEPTH = 2
) (
  input logic               g_clk,
  input logic               g_reset,
  frv_pipeline_fifo_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RLEN-1:0] mem_q [DEPTH];
  logic [RLEN-1:0] mem_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [RLEN-1:0] data_q, data_d;
  logic [RLEN-1:0] mr_q, mr_d;
  logic            busy, valid, push, pop;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid       = (count_q != '0);
  assign busy        = (count_q == CW'(DEPTH));
  assign bus.o_valid = valid;
  assign bus.o_busy  = busy;
  assign bus.o_count = count_q;
  assign bus.o_data  = data_q;
  assign bus.mr_data = mr_q;

  always_comb begin
    push    = bus.i_valid && !busy;
    pop     = valid && !bus.i_busy;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    data_d  = data_q;
    mr_d    = mr_q;
    mem_d   = mem_q;
    if (bus.flush) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      data_d  = bus.flush_dat;
      mr_d    = bus.flush_dat;
    end else begin
      if (push) begin
        mem_d[wptr_q] = bus.i_data;
        wptr_d        = ptr_inc(wptr_q);
        mr_d          = bus.i_data;
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // Head register: next-oldest entry on pop, or the incoming word when it becomes head.
      if (pop && (count_q > CW'(1))) begin
        data_d = mem_q[ptr_inc(rptr_q)];
      end else if (push && ((count_q == '0) || (pop && (count_q == CW'(1))))) begin
        data_d = bus.i_data;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      data_q  <= '0;
      mr_q    <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      data_q  <= data_d;
      mr_q    <= mr_d;
    end
  end

  // Storage contents beyond count are never observed, so they need no reset.
  always_ff @(posedge g_clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_frv_pipeline_fifo.sv
// Directed bench for frv_pipeline_fifo: four instances (DEPTH 2, 4, 1, 3) sharing clock/reset.
module tb_frv_pipeline_fifo;
  logic g_clk = 1'b0;
  logic g_reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 g_clk = ~g_clk;

  frv_pipeline_fifo_if #(.RLEN(8), .DEPTH(2)) if2 ();
  frv_pipeline_fifo_if #(.RLEN(8), .DEPTH(4)) if4 ();
  frv_pipeline_fifo_if #(.RLEN(8), .DEPTH(1)) if1 ();
  frv_pipeline_fifo_if #(.RLEN(8), .DEPTH(3)) if3 ();

  frv_pipeline_fifo #(.RLEN(8), .DEPTH(2)) u_d2 (.g_clk(g_clk), .g_reset(g_reset), .bus(if2));
  frv_pipeline_fifo #(.RLEN(8), .DEPTH(4)) u_d4 (.g_clk(g_clk), .g_reset(g_reset), .bus(if4));
  frv_pipeline_fifo #(.RLEN(8), .DEPTH(1)) u_d1 (.g_clk(g_clk), .g_reset(g_reset), .bus(if1));
  frv_pipeline_fifo #(.RLEN(8), .DEPTH(3)) u_d3 (.g_clk(g_clk), .g_reset(g_reset), .bus(if3));

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int cnt_m, sent, recv;
    logic cur_valid, cur_busy, push_m, pop_m;

    {if2.i_data, if2.i_valid, if2.flush, if2.flush_dat, if2.i_busy} = '0;
    {if4.i_data, if4.i_valid, if4.flush, if4.flush_dat, if4.i_busy} = '0;
    {if1.i_data, if1.i_valid, if1.flush, if1.flush_dat, if1.i_busy} = '0;
    {if3.i_data, if3.i_valid, if3.flush, if3.flush_dat, if3.i_busy} = '0;
    tick();
    tick();
    g_reset = 1'b0;

    // Reset state
    chk("rst_valid", if2.o_valid, 0);
    chk("rst_busy", if2.o_busy, 0);
    chk("rst_data", if2.o_data, 0);
    chk("rst_mr", if2.mr_data, 0);
    chk("rst_count", if2.o_count, 0);

    // Stream on DEPTH=2: one transfer per cycle, count stays 1
    if2.i_valid = 1'b1;
    if2.i_data  = 8'h11;
    tick();
    chk("s_data11", if2.o_data, 8'h11);
    chk("s_valid", if2.o_valid, 1);
    chk("s_count1", if2.o_count, 1);
    if2.i_data = 8'h22;
    tick();
    chk("s_data22", if2.o_data, 8'h22);
    chk("s_count2", if2.o_count, 1);
    chk("s_busy2", if2.o_busy, 0);
    if2.i_data = 8'h33;
    tick();
    chk("s_data33", if2.o_data, 8'h33);
    chk("s_count3", if2.o_count, 1);
    chk("s_mr33", if2.mr_data, 8'h33);
    if2.i_valid = 1'b0;
    tick();
    chk("s_drain_valid", if2.o_valid, 0);
    chk("s_drain_hold", if2.o_data, 8'h33);

    // Fill and stall on DEPTH=4
    if4.i_busy  = 1'b1;
    if4.i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if4.i_data = 8'hA0 + 8'(k);
      tick();
    end
    chk("f_count", if4.o_count, 4);
    chk("f_busy", if4.o_busy, 1);
    chk("f_head", if4.o_data, 8'hA0);
    chk("f_mr", if4.mr_data, 8'hA3);
    if4.i_busy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("f_order", if4.o_data, 8'hA0 + k);
      chk("f_ovalid", if4.o_valid, 1);
      tick();
      if (k == 1) if4.i_valid = 1'b0;
    end
    chk("f_empty", if4.o_valid, 0);
    chk("f_count0", if4.o_count, 0);

    // Full pop-and-push edge on DEPTH=1
    if1.i_busy  = 1'b1;
    if1.i_valid = 1'b1;
    if1.i_data  = 8'h5A;
    tick();
    chk("p_full_busy", if1.o_busy, 1);
    chk("p_full_data", if1.o_data, 8'h5A);
    if1.i_data = 8'h6B;
    if1.i_busy = 1'b0;
    tick();
    chk("p_c1_count", if1.o_count, 0);
    chk("p_c1_valid", if1.o_valid, 0);
    chk("p_c1_busy", if1.o_busy, 0);
    tick();
    if1.i_valid = 1'b0;
    chk("p_c2_data", if1.o_data, 8'h6B);
    chk("p_c2_valid", if1.o_valid, 1);
    tick();
    chk("p_drain", if1.o_valid, 0);

    // Flush mid-stream on DEPTH=3
    if3.i_busy  = 1'b1;
    if3.i_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if3.i_data = 8'(k);
      tick();
    end
    chk("fl_full", if3.o_count, 3);
    if3.flush     = 1'b1;
    if3.flush_dat = 8'hFF;
    if3.i_data    = 8'h04;
    if3.i_busy    = 1'b0;
    tick();
    if3.flush   = 1'b0;
    if3.i_valid = 1'b0;
    chk("fl_valid", if3.o_valid, 0);
    chk("fl_count", if3.o_count, 0);
    chk("fl_data", if3.o_data, 8'hFF);
    chk("fl_mr", if3.mr_data, 8'hFF);
    chk("fl_busy", if3.o_busy, 0);
    tick();
    tick();
    chk("fl_stays_empty", if3.o_valid, 0);
    chk("fl_stays_data", if3.o_data, 8'hFF);

    // Pointer wrap on DEPTH=3 with random handshakes, words = sequence index
    cnt_m = 0;
    sent = 0;
    recv = 0;
    cur_valid = 1'b0;
    for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
      chk("w_count", if3.o_count, cnt_m);
      chk("w_busy", if3.o_busy, cnt_m == 3);
      chk("w_valid", if3.o_valid, cnt_m != 0);
      if (cnt_m != 0) chk("w_data", if3.o_data, q[0]);
      if (!cur_valid && sent < 20) cur_valid = ($urandom_range(0, 3) != 0);
      cur_busy = ($urandom_range(0, 2) == 0);
      push_m = cur_valid && (cnt_m < 3);
      pop_m  = (cnt_m != 0) && !cur_busy;
      if3.i_valid = cur_valid;
      if3.i_data  = 8'(sent);
      if3.i_busy  = cur_busy;
      if (pop_m) begin
        void'(q.pop_front());
        recv++;
        cnt_m--;
      end
      if (push_m) begin
        q.push_back(sent);
        sent++;
        cnt_m++;
        cur_valid = 1'b0;
      end
      tick();
    end
    if3.i_valid = 1'b0;
    chk("w_all_received", recv, 20);

    // Reset mid-operation on a full DEPTH=2 queue
    if2.i_busy  = 1'b1;
    if2.i_valid = 1'b1;
    if2.i_data  = 8'h71;
    tick();
    if2.i_data = 8'h72;
    tick();
    chk("r_full", if2.o_busy, 1);
    g_reset       = 1'b1;
    if2.flush     = 1'b1;
    if2.flush_dat = 8'hEE;
    if2.i_data    = 8'h73;
    if2.i_busy    = 1'b0;
    tick();
    g_reset   = 1'b0;
    if2.flush = 1'b0;
    if2.i_valid = 1'b0;
    chk("r_valid", if2.o_valid, 0);
    chk("r_busy", if2.o_busy, 0);
    chk("r_data", if2.o_data, 0);
    chk("r_mr", if2.mr_data, 0);
    chk("r_count", if2.o_count, 0);
    if2.i_valid = 1'b1;
    if2.i_data  = 8'h99;
    tick();
    if2.i_valid = 1'b0;
    chk("r_first", if2.o_data, 8'h99);
    chk("r_first_count", if2.o_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
